window_stitcher: RTL and testbench

// Overlap-add stage directly upstream of the emitter. Accepts pitch-shifted

---
 rtl/window_stitcher.sv | 178 +++++++++++++++++
 tb/tb_window_stitcher.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/window_stitcher.sv
// window_stitcher: overlap-add of 2*HOP-sample windows into a 4-segment ring buffer.
// Rev 1.0
`default_nettype none

module window_stitcher #(
  parameter int DATA_W = 16,
  parameter int HOP    = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_sop,
  output logic                     in_ready,
  output logic                     go_out,
  output logic [1:0]               window_start,
  input  logic [$clog2(4*HOP)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy
);

  localparam int DEPTH = 4 * HOP;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(2 * HOP);
  localparam int HB    = $clog2(HOP);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [DATA_W-1:0] C_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] C_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [1:0]        k_q, k_d;
  logic [AW-1:0]     clr_q, clr_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_acc_q, wr_acc_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_sample_q, wr_sample_d;
  logic              go_out_q, go_out_d;
  logic [1:0]        window_start_q, window_start_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] old_q, old_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W:0]   sum;

  logic              xfer;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     cur_addr;

  assign xfer      = in_valid && in_ready;
  assign base_addr = {k_q, {HB{1'b0}}};
  assign cur_addr  = base_addr + {{(AW-IW){1'b0}}, i_q};

  // State register plus the one-cycle write pipeline of the read-modify-write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_CLEAR;
      i_q            <= '0;
      k_q            <= '0;
      clr_q          <= '0;
      wr_en_q        <= 1'b0;
      wr_acc_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_sample_q    <= '0;
      go_out_q       <= 1'b0;
      window_start_q <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      k_q            <= k_d;
      clr_q          <= clr_d;
      wr_en_q        <= wr_en_d;
      wr_acc_q       <= wr_acc_d;
      wr_addr_q      <= wr_addr_d;
      wr_sample_q    <= wr_sample_d;
      go_out_q       <= go_out_d;
      window_start_q <= window_start_d;
      rd_data_q      <= rd_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    k_d         = k_q;
    clr_d       = clr_q;
    wr_en_d     = 1'b0;
    wr_acc_d    = 1'b0;
    wr_addr_d   = cur_addr;
    wr_sample_d = in_data;
    case (state_q)
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == AW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (xfer && in_sop) begin
          wr_en_d   = 1'b1;
          wr_acc_d  = 1'b1;
          wr_addr_d = base_addr;
          i_d       = IW'(1);
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM, S_WRITE: begin
        if (xfer && in_sop) begin
          // Restart in place: same segment, earlier writes are left as they are.
          wr_en_d   = 1'b1;
          wr_acc_d  = 1'b1;
          wr_addr_d = base_addr;
          i_d       = IW'(1);
          state_d   = S_ACCUM;
        end else if (xfer) begin
          wr_en_d  = 1'b1;
          wr_acc_d = (state_q == S_ACCUM);
          i_d      = i_q + 1'b1;
          if (state_q == S_ACCUM && i_q == IW'(HOP - 1)) state_d = S_WRITE;
          if (state_q == S_WRITE && i_q == IW'(2 * HOP - 1)) begin
            state_d = S_DONE;
            i_d     = '0;
          end
        end
      end
      S_DONE: begin
        k_d     = k_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    in_ready       = (state_q == S_IDLE) || (state_q == S_ACCUM) || (state_q == S_WRITE);
    busy           = (state_q == S_CLEAR);
    go_out_d       = (state_q == S_DONE);
    window_start_d = (state_q == S_DONE) ? k_q : window_start_q;
  end

  assign go_out       = go_out_q;
  assign window_start = window_start_q;
  assign rd_data      = rd_data_q;

  // Saturating add at DATA_W+1 bits; overflow shows as disagreeing top two bits.
  always_comb begin
    sum       = {old_q[DATA_W-1], old_q} + {wr_sample_q[DATA_W-1], wr_sample_q};
    mem_we    = (state_q == S_CLEAR) || wr_en_q;
    mem_waddr = (state_q == S_CLEAR) ? clr_q : wr_addr_q;
    if (state_q == S_CLEAR) begin
      mem_wdata = '0;
    end else if (!wr_acc_q) begin
      mem_wdata = wr_sample_q;
    end else if (sum[DATA_W] != sum[DATA_W-1]) begin
      mem_wdata = sum[DATA_W] ? C_MIN : C_MAX;
    end else begin
      mem_wdata = sum[DATA_W-1:0];
    end
    old_d     = mem_q[wr_addr_d];
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    old_q <= old_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_window_stitcher.sv
// tb_window_stitcher: directed self-checking bench for window_stitcher (HOP=512).
`default_nettype none

module tb_window_stitcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_ready;
  logic        go_out;
  logic [1:0]  window_start;
  logic [10:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [15:0] NEG30K  = 16'(-30000);
  localparam logic [15:0] NEG28950 = 16'(-28950);

  window_stitcher #(.DATA_W(16), .HOP(512)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_ready     (in_ready),
    .go_out       (go_out),
    .window_start (window_start),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int c = 0;
    while (in_ready !== 1'b1 && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 4000) begin
      n_assert++;
      n_fail++;
      $error("FAIL ready_timeout: observed in_ready=%b expected 1", in_ready);
    end
  endtask

  // Sends n samples of one value; optional sop on the first and idle gaps carrying junk.
  task automatic send_samples(input logic [15:0] val, input int n, input bit sop_first,
                              input bit gaps);
    for (int j = 0; j < n; j++) begin
      if (gaps) begin
        in_valid = 1'b0; in_sop = 1'b1; in_data = 16'h7abc;
        @(posedge clk); #1;
      end
      wait_ready();
      in_valid = 1'b1;
      in_sop   = sop_first && (j == 0);
      in_data  = val;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  // Entered one cycle after the last accepted sample.
  task automatic check_go(input logic [1:0] ws, input string tag);
    chk({tag, "_go_early"}, 32'(go_out), 32'd0);
    chk({tag, "_ready_done"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_go_pulse"}, 32'(go_out), 32'd1);
    chk({tag, "_ws"}, 32'(window_start), 32'(ws));
    @(posedge clk); #1;
    chk({tag, "_go_width"}, 32'(go_out), 32'd0);
    chk({tag, "_ws_hold"}, 32'(window_start), 32'(ws));
    chk({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic check_range(input int lo, input int hi, input logic [15:0] exp,
                             input string tag);
    int          bad = 0;
    int          first = -1;
    logic [15:0] fval = '0;
    for (int a = lo; a <= hi; a++) begin
      rd_addr = 11'(a);
      @(posedge clk); #1;
      if (rd_data !== exp) begin
        if (bad == 0) begin first = a; fval = rd_data; end
        bad++;
      end
    end
    n_assert++;
    assert (bad == 0) else begin
      n_fail++;
      $error("FAIL %s: %0d bad words, addr %0d observed 0x%0h expected 0x%0h",
             tag, bad, first, fval, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    int cnt = 0;
    in_valid = 1'b0; in_sop = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_rst_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_rst_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rst_go"}, 32'(go_out), 32'd0);
    chk({tag, "_rst_ws"}, 32'(window_start), 32'd0);
    chk({tag, "_rst_rd"}, 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    while (in_ready !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_clear_cycles"}, 32'(cnt), 32'd2048);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_range(0, 2047, 16'd0, {tag, "_all_zero"});
  endtask

  initial begin
    // Phase 1: clear, window A then B.
    do_reset("p1");
    send_samples(16'd100, 1024, 1'b1, 1'b0);
    check_go(2'd0, "winA");
    check_range(0, 1023, 16'd100, "winA_data");
    check_range(1024, 2047, 16'd0, "winA_rest");
    send_samples(16'd200, 1024, 1'b1, 1'b0);
    check_go(2'd1, "winB");
    check_range(0, 511, 16'd100, "winB_keep");
    check_range(512, 1023, 16'd300, "winB_overlap");
    check_range(1024, 1535, 16'd200, "winB_tail");
    check_range(1536, 2047, 16'd0, "winB_rest");

    // Phase 2: B again with gaps, then wrap-around and saturation.
    do_reset("p2");
    send_samples(16'd100, 1024, 1'b1, 1'b0);
    check_go(2'd0, "p2A");
    send_samples(16'd200, 1024, 1'b1, 1'b1);
    check_go(2'd1, "gapB");
    check_range(512, 1023, 16'd300, "gapB_overlap");
    check_range(1024, 1535, 16'd200, "gapB_tail");
    send_samples(16'd300, 1024, 1'b1, 1'b0);
    check_go(2'd2, "winC");
    check_range(1024, 1535, 16'd500, "winC_overlap");
    send_samples(16'd400, 1024, 1'b1, 1'b0);
    check_go(2'd3, "winD");
    check_range(1536, 2047, 16'd700, "winD_overlap");
    check_range(0, 511, 16'd400, "winD_wrap");
    send_samples(16'd10, 1024, 1'b1, 1'b0);
    check_go(2'd0, "winE");
    check_range(0, 511, 16'd410, "winE_overlap");
    check_range(512, 1023, 16'd10, "winE_tail");
    send_samples(16'd30000, 1024, 1'b1, 1'b0);
    check_go(2'd1, "winF");
    send_samples(16'd30000, 1024, 1'b1, 1'b0);
    check_go(2'd2, "satPos");
    check_range(1024, 1535, 16'h7fff, "satPos_data");
    check_range(1536, 2047, 16'd30000, "satPos_tail");
    send_samples(NEG30K, 1024, 1'b1, 1'b0);
    check_go(2'd3, "winH");
    check_range(1536, 2047, 16'd0, "winH_cancel");
    send_samples(NEG30K, 1024, 1'b1, 1'b0);
    check_go(2'd0, "satNeg");
    check_range(0, 511, 16'h8000, "satNeg_data");
    check_range(512, 1023, NEG30K, "satNeg_tail");

    // Phase 3: IDLE drop, abort via sop, reset mid-window.
    send_samples(16'd555, 5, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_drop_go", 32'(go_out), 32'd0);
    check_range(512, 516, NEG30K, "idle_drop_data");
    send_samples(16'd1000, 700, 1'b1, 1'b0);
    chk("abort_no_go", 32'(go_out), 32'd0);
    send_samples(16'd50, 1024, 1'b1, 1'b0);
    check_go(2'd1, "abort");
    check_range(512, 1023, NEG28950, "abort_overlap");
    check_range(1024, 1535, 16'd50, "abort_tail");
    check_range(1536, 2047, 16'd0, "abort_rest");
    send_samples(16'd77, 300, 1'b1, 1'b0);
    do_reset("midrst");
    send_samples(16'd100, 1024, 1'b1, 1'b0);
    check_go(2'd0, "postrst");
    check_range(0, 1023, 16'd100, "postrst_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
